// File: rtl/ysyx_23060020_mem_arb_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM states, grant ids,
// default bus widths.
package ysyx_23060020_mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060020_wdt.sv
// Response watchdog for the memory arbiter.
//   clr    : restart counting from zero (request handshake)
//   en     : one more cycle spent waiting without a response
//   expire : counter has reached TIMEOUT-1 (never high when TIMEOUT == 0)
// The counter saturates at TIMEOUT-1 and never wraps.
module ysyx_23060020_wdt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/ysyx_23060020_mem_arb.sv
// Round-robin arbiter sharing one memory port between IFU (fetch) and LSU
// (load/store). The winning request is latched, presented to memory with a
// valid/ready handshake, and the response is routed back to its owner.
// A watchdog converts a missing response into an error response.
//   ifu_* : fetch request/response channel
//   lsu_* : load/store request/response channel
//   mem_* : shared memory request/response channel
//   busy  : a transaction is owned (state is not IDLE)
module ysyx_23060020_mem_arb
  import ysyx_23060020_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_req_ready,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_req_ready,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  state_t              state;
  logic                last_grant;
  logic                owner;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;

  logic grant_ifu, grant_lsu;
  logic resp_fire, timeout_fire, done;
  logic wdt_expire;

  always_comb begin
    grant_lsu = (state == IDLE) && lsu_req_valid &&
                (!ifu_req_valid || (last_grant == GNT_IFU));
    grant_ifu = (state == IDLE) && ifu_req_valid && !grant_lsu;
  end

  // A real response in the expiry cycle takes precedence over the timeout.
  assign resp_fire    = (state == WAIT) && mem_resp_valid;
  assign timeout_fire = (state == WAIT) && !mem_resp_valid && wdt_expire;
  assign done         = resp_fire || timeout_fire;

  ysyx_23060020_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    ((state == REQ) && mem_req_ready),
    .en     ((state == WAIT) && !mem_resp_valid),
    .expire (wdt_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_IFU;
      owner      <= GNT_IFU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_lsu) begin
            addr_q     <= lsu_addr;
            wen_q      <= lsu_wen;
            wdata_q    <= lsu_wdata;
            wmask_q    <= lsu_wmask;
            owner      <= GNT_LSU;
            last_grant <= GNT_LSU;
            state      <= REQ;
          end else if (grant_ifu) begin
            addr_q     <= ifu_addr;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            owner      <= GNT_IFU;
            last_grant <= GNT_IFU;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is gated by rst_n so it stays low while reset is held.
  assign ifu_req_ready  = rst_n && grant_ifu;
  assign lsu_req_ready  = rst_n && grant_lsu;

  assign ifu_resp_valid = done && (owner == GNT_IFU);
  assign ifu_resp_err   = timeout_fire && (owner == GNT_IFU);
  assign ifu_rdata      = (resp_fire && (owner == GNT_IFU)) ? mem_rdata : '0;

  assign lsu_resp_valid = done && (owner == GNT_LSU);
  assign lsu_resp_err   = timeout_fire && (owner == GNT_LSU);
  assign lsu_rdata      = (resp_fire && (owner == GNT_LSU)) ? mem_rdata : '0;

  assign mem_req_valid  = (state == REQ);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_ysyx_23060020_mem_arb.sv
module tb_ysyx_23060020_mem_arb;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifu_req_valid;
  logic [AW-1:0] ifu_addr;
  logic          ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_wen;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [3:0]    lsu_wmask;
  logic          lsu_req_ready, lsu_resp_valid, lsu_resp_err;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wmask;
  logic          busy;

  int checks = 0;
  int errors = 0;

  ysyx_23060020_mem_arb #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_addr       (ifu_addr),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .ifu_resp_err   (ifu_resp_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .lsu_resp_err   (lsu_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One outstanding transaction at most; tracked as "held", "accepted by
  // memory" and "cycles waited so far".
  bit          m_have, m_issued, m_lsu, m_last_lsu, m_wen;
  int unsigned m_waited;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wmask;

  always @(negedge clk) begin
    bit win, win_lsu, fin, err;
    logic [31:0] rd;
    if (!rst_n) begin
      m_have = 0; m_issued = 0; m_last_lsu = 0; m_waited = 0;
      check("rst_busy", busy, 0);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_ifu_req_ready", ifu_req_ready, 0);
      check("rst_lsu_req_ready", lsu_req_ready, 0);
      check("rst_ifu_resp", {ifu_resp_valid, ifu_resp_err}, 0);
      check("rst_lsu_resp", {lsu_resp_valid, lsu_resp_err}, 0);
      check("rst_rdata", {ifu_rdata, lsu_rdata}, 0);
      check("rst_mem_bus", {mem_addr, mem_wen, mem_wmask}, 0);
      check("rst_mem_wdata", mem_wdata, 0);
    end else begin
      win = 0; win_lsu = 0; fin = 0; err = 0; rd = '0;
      if (!m_have) begin
        if (ifu_req_valid && lsu_req_valid) begin win = 1; win_lsu = !m_last_lsu; end
        else if (lsu_req_valid) begin win = 1; win_lsu = 1; end
        else if (ifu_req_valid) begin win = 1; win_lsu = 0; end
      end else if (m_issued) begin
        fin = mem_resp_valid || (m_waited == TMO - 1);
        err = fin && !mem_resp_valid;
        rd  = err ? 32'h0 : mem_rdata;
      end
      check("m_busy", busy, m_have);
      check("m_ifu_req_ready", ifu_req_ready, win && !win_lsu);
      check("m_lsu_req_ready", lsu_req_ready, win && win_lsu);
      check("m_mem_req_valid", mem_req_valid, m_have && !m_issued);
      if (m_have && !m_issued) begin
        check("m_mem_addr", mem_addr, m_addr);
        check("m_mem_wen", mem_wen, m_wen);
        check("m_mem_wdata", mem_wdata, m_wdata);
        check("m_mem_wmask", mem_wmask, m_wmask);
      end
      check("m_ifu_resp_valid", ifu_resp_valid, fin && !m_lsu);
      check("m_ifu_resp_err", ifu_resp_err, err && !m_lsu);
      check("m_lsu_resp_valid", lsu_resp_valid, fin && m_lsu);
      check("m_lsu_resp_err", lsu_resp_err, err && m_lsu);
      if (fin) begin
        check("m_ifu_rdata", ifu_rdata, m_lsu ? 32'h0 : rd);
        check("m_lsu_rdata", lsu_rdata, m_lsu ? rd : 32'h0);
      end
      // advance to next cycle
      if (!m_have) begin
        if (win) begin
          m_have = 1; m_issued = 0; m_lsu = win_lsu; m_last_lsu = win_lsu;
          m_addr  = win_lsu ? lsu_addr : ifu_addr;
          m_wen   = win_lsu ? lsu_wen : 1'b0;
          m_wdata = win_lsu ? lsu_wdata : 32'h0;
          m_wmask = win_lsu ? lsu_wmask : 4'h0;
        end
      end else if (!m_issued) begin
        if (mem_req_ready) begin m_issued = 1; m_waited = 0; end
      end else if (fin) begin
        m_have = 0;
      end else begin
        m_waited++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    tick(); tick(); settle();
    check("reset_busy", busy, 0);
    check("reset_mem_req_valid", mem_req_valid, 0);
    tick(); rst_n = 1;

    // 1: IFU alone
    tick(); ifu_req_valid = 1; ifu_addr = 32'h8000_0000; settle();
    check("t1_ifu_req_ready", ifu_req_ready, 1);
    check("t1_lsu_req_ready", lsu_req_ready, 0);
    tick(); ifu_req_valid = 0; mem_req_ready = 1; settle();
    check("t1_mem_req_valid", mem_req_valid, 1);
    check("t1_mem_addr", mem_addr, 32'h8000_0000);
    check("t1_mem_wen", mem_wen, 0);
    tick(); mem_req_ready = 0; settle();
    check("t1_no_early_resp", ifu_resp_valid, 0);
    tick(); mem_resp_valid = 1; mem_rdata = 32'h0010_0073; settle();
    check("t1_ifu_resp_valid", ifu_resp_valid, 1);
    check("t1_ifu_rdata", ifu_rdata, 32'h0010_0073);
    check("t1_ifu_resp_err", ifu_resp_err, 0);
    check("t1_lsu_resp_valid", lsu_resp_valid, 0);
    tick(); mem_resp_valid = 0; settle();
    check("t1_busy_drop", busy, 0);

    // 2: both requesters held continuously -> LSU, IFU, LSU, IFU
    for (int k = 0; k < 12; k++) begin
      bit exp_lsu;
      tick();
      if (k == 0) begin
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
        mem_req_ready = 1; mem_resp_valid = 1;
      end
      mem_rdata = 32'hA000_0000 + k;
      settle();
      exp_lsu = ((k / 3) % 2) == 0;
      case (k % 3)
        0: begin
          check("t2_lsu_grant", lsu_req_ready, exp_lsu);
          check("t2_ifu_grant", ifu_req_ready, !exp_lsu);
        end
        1: check("t2_mem_addr", mem_addr, exp_lsu ? 32'h8000_2000 : 32'h8000_0004);
        default: begin
          check("t2_lsu_resp", lsu_resp_valid, exp_lsu);
          check("t2_ifu_resp", ifu_resp_valid, !exp_lsu);
          check("t2_rdata", exp_lsu ? lsu_rdata : ifu_rdata, 32'hA000_0000 + k);
        end
      endcase
    end
    tick();
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
    settle();
    check("t2_idle", busy, 0);

    // 3: LSU store with mem_req_ready delayed 3 cycles
    tick(); lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; settle();
    check("t3_lsu_req_ready", lsu_req_ready, 1);
    for (int r = 0; r < 4; r++) begin
      tick();
      if (r == 0) begin
        lsu_req_valid = 0; lsu_addr = 32'h0BAD_0000; lsu_wen = 0;
        lsu_wdata = '0; lsu_wmask = '0; ifu_req_valid = 1;
      end
      mem_req_ready = (r == 3);
      mem_resp_valid = (r == 1);
      settle();
      check("t3_mem_req_valid", mem_req_valid, 1);
      check("t3_mem_addr", mem_addr, 32'h8000_1000);
      check("t3_mem_wen", mem_wen, 1);
      check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("t3_mem_wmask", mem_wmask, 4'hF);
      check("t3_ifu_req_ready", ifu_req_ready, 0);
      check("t3_lsu_resp_in_req", lsu_resp_valid, 0);
    end
    tick(); ifu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 1;
    mem_rdata = 32'h1234_5678; settle();
    check("t3_lsu_resp_valid", lsu_resp_valid, 1);
    check("t3_lsu_resp_err", lsu_resp_err, 0);
    check("t3_ifu_resp_valid", ifu_resp_valid, 0);
    tick(); mem_resp_valid = 0; settle();
    check("t3_busy_drop", busy, 0);

    // 4: timeout, memory never responds
    tick(); ifu_req_valid = 1; ifu_addr = 32'h8000_0010; mem_rdata = 32'hFFFF_FFFF; settle();
    check("t4_ifu_req_ready", ifu_req_ready, 1);
    tick(); ifu_req_valid = 0; mem_req_ready = 1; settle();
    check("t4_handshake", mem_req_valid, 1);
    for (int w = 1; w <= 4; w++) begin
      tick(); mem_req_ready = 0; settle();
      if (w < 4) begin
        check("t4_no_resp_yet", ifu_resp_valid, 0);
        check("t4_busy", busy, 1);
      end else begin
        check("t4_err_valid", ifu_resp_valid, 1);
        check("t4_err_flag", ifu_resp_err, 1);
        check("t4_err_rdata", ifu_rdata, 32'h0);
        check("t4_lsu_quiet", lsu_resp_valid, 0);
      end
    end
    tick(); settle();
    check("t4_idle", busy, 0);

    // 4b: response in the expiry cycle wins
    tick(); lsu_req_valid = 1; lsu_addr = 32'h8000_0020; lsu_wen = 0; settle();
    check("t4b_lsu_req_ready", lsu_req_ready, 1);
    tick(); lsu_req_valid = 0; mem_req_ready = 1; settle();
    for (int w = 1; w <= 4; w++) begin
      tick(); mem_req_ready = 0; mem_resp_valid = (w == 4); mem_rdata = 32'hCAFE_F00D; settle();
      if (w == 4) begin
        check("t4b_resp_valid", lsu_resp_valid, 1);
        check("t4b_resp_err", lsu_resp_err, 0);
        check("t4b_rdata", lsu_rdata, 32'hCAFE_F00D);
      end
    end
    tick(); mem_resp_valid = 0; settle();
    check("t4b_idle", busy, 0);

    // 5: reset during WAIT (last grant is LSU beforehand)
    tick(); lsu_req_valid = 1; lsu_addr = 32'h8000_0040; settle();
    check("t5_lsu_req_ready", lsu_req_ready, 1);
    tick(); lsu_req_valid = 0; mem_req_ready = 1; settle();
    tick(); mem_req_ready = 0; ifu_req_valid = 1; lsu_req_valid = 1; settle();
    check("t5_busy_wait", busy, 1);
    rst_n = 0; #1;
    check("t5_async_busy", busy, 0);
    check("t5_async_ready", {ifu_req_ready, lsu_req_ready}, 0);
    check("t5_async_mem", {mem_req_valid, mem_addr}, 0);
    tick(); settle();
    check("t5_held_ready", {ifu_req_ready, lsu_req_ready}, 0);
    tick(); rst_n = 1; mem_resp_valid = 1; mem_rdata = 32'h0DDB_A11D; settle();
    check("t5_tie_lsu", lsu_req_ready, 1);
    check("t5_tie_ifu", ifu_req_ready, 0);
    check("t5_no_stale_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    tick(); ifu_req_valid = 0; lsu_req_valid = 0; mem_resp_valid = 0; mem_req_ready = 1; settle();
    check("t5_mem_addr", mem_addr, 32'h8000_0040);
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h5555_AAAA; settle();
    check("t5_lsu_resp", lsu_resp_valid, 1);
    tick(); mem_resp_valid = 0; settle();
    check("t5_idle", busy, 0);

    // 6: stray responses in IDLE and REQ
    tick(); mem_resp_valid = 1; mem_rdata = 32'h7777_7777; settle();
    check("t6_idle_stray", {ifu_resp_valid, lsu_resp_valid, busy}, 0);
    tick(); settle();
    check("t6_idle_stray2", {ifu_resp_valid, lsu_resp_valid, busy}, 0);
    tick(); ifu_req_valid = 1; ifu_addr = 32'h8000_0050; settle();
    check("t6_ifu_req_ready", ifu_req_ready, 1);
    check("t6_no_resp_grant", ifu_resp_valid, 0);
    tick(); ifu_req_valid = 0; settle();
    check("t6_req_hold", mem_req_valid, 1);
    check("t6_req_stray", ifu_resp_valid, 0);
    tick(); mem_req_ready = 1; settle();
    check("t6_req_stray2", ifu_resp_valid, 0);
    tick(); mem_req_ready = 0; mem_rdata = 32'h0000_0013; settle();
    check("t6_resp", ifu_resp_valid, 1);
    check("t6_rdata", ifu_rdata, 32'h0000_0013);
    tick(); mem_resp_valid = 0; settle();
    check("t6_idle", busy, 0);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
